// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Purpose : Definitions shared by the memory bus arbiter and its counter
//           helper.
//           - FSM state encoding: IDLE / ACCESS / RESP.
//           - Bus owner encoding: NONE / CPU / DMA. This value is also
//             driven on the owner port.
//           - Default bus widths used by the arbiter control unit.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Purpose : Saturating up-counter with a synchronous clear. at_limit_o is
//           asserted while the count equals LIMIT.
//           The arbiter uses two instances:
//           - one to track consecutive DMA losses;
//           - one to count ACCESS-phase wait cycles.
// Ports   : clk        - clock
//           rst        - asynchronous active-high reset (count -> 0)
//           inc_i      - increment by one, holding once LIMIT is reached
//           clr_i      - clear to zero; takes priority over inc_i
//           at_limit_o - count == LIMIT
// ---------------------------------------------------------------------------
module arb_starve_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Clear has priority over increment.
  // The increment stops once the limit is reached, so the count
  // saturates and never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT_VAL)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  assign at_limit_o = (count_q == LIMIT_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Purpose : Shares one external memory bus between the CPU and DMA
//           requesters.
//           - The CPU has fixed priority.
//           - After STARVE_LIMIT consecutive losses, the DMA is forced
//             to win.
//           - Each access waits for mem_ready and is aborted with err
//             after TIMEOUT cycles.
// Ports   : clk, rst              - clock, async active-high reset
//           cpu_req/rw/addr/wdata - CPU request bundle, held until cpu_ack
//           cpu_ack               - one-cycle completion pulse to the CPU
//           dma_req/rw/addr/wdata - DMA request bundle, held until dma_ack
//           dma_ack               - one-cycle completion pulse to the DMA
//           rdata, err            - read data / timeout flag in the ack cycle
//           mem_en/rw/addr/wdata  - registered memory bus outputs
//           mem_rdata, mem_ready  - memory read data / access complete
//           owner                 - 00 none, 01 CPU, 10 DMA
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  input  logic                  dma_req,
  input  logic                  dma_rw,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            owner
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  memEn_q, memEn_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  cpuAck_q, cpuAck_d;
  logic                  dmaAck_q, dmaAck_d;

  logic starveInc, starveClr, starveAtLimit;
  logic tmoInc, tmoClr, tmoAtLimit;
  logic dmaWins;

  // Consecutive DMA losses. Once this counter saturates, a pending DMA
  // request beats the CPU.
  arb_starve_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (starveInc),
    .clr_i      (starveClr),
    .at_limit_o (starveAtLimit)
  );

  // ACCESS-cycle counter. The limit is TIMEOUT-1 because the abort
  // decision is made in the TIMEOUT-th ACCESS cycle itself, before that
  // cycle's increment lands. This keeps mem_en high for exactly TIMEOUT
  // cycles.
  arb_starve_counter #(
    .WIDTH (8),
    .LIMIT (TIMEOUT - 1)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (tmoInc),
    .clr_i      (tmoClr),
    .at_limit_o (tmoAtLimit)
  );

  assign tmoInc  = (state_q == ST_ACCESS);
  assign tmoClr  = (state_q == ST_RESP);
  assign dmaWins = dma_req && (starveAtLimit || !cpu_req);

  // State and registered bus/response outputs. An asynchronous reset
  // abandons any access in flight without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      memEn_q  <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cpuAck_q <= 1'b0;
      dmaAck_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      memEn_q  <= memEn_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cpuAck_q <= cpuAck_d;
      dmaAck_q <= dmaAck_d;
    end
  end

  // Next-state logic.
  // - IDLE arbitrates and latches the winner's request into the bus
  //   registers. Requester inputs are not looked at again until IDLE.
  // - ACCESS waits for mem_ready or for the timeout. mem_ready is tested
  //   first, so a completion in the expiry cycle is not an error.
  // - RESP pulses the owner's ack, then releases the bus.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    memEn_d   = 1'b0;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cpuAck_d  = 1'b0;
    dmaAck_d  = 1'b0;
    starveInc = 1'b0;
    starveClr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = ST_ACCESS;
          memEn_d = 1'b1;
          err_d   = 1'b0;
          if (dmaWins) begin
            owner_d   = OWN_DMA;
            rw_d      = dma_rw;
            addr_d    = dma_addr;
            wdata_d   = dma_wdata;
            starveClr = 1'b1;
          end else begin
            owner_d   = OWN_CPU;
            rw_d      = cpu_rw;
            addr_d    = cpu_addr;
            wdata_d   = cpu_wdata;
            starveInc = dma_req;
          end
        end
      end

      ST_ACCESS: begin
        memEn_d = 1'b1;
        if (mem_ready || tmoAtLimit) begin
          state_d  = ST_RESP;
          memEn_d  = 1'b0;
          cpuAck_d = (owner_q == OWN_CPU);
          dmaAck_d = (owner_q == OWN_DMA);
          if (mem_ready) begin
            err_d = 1'b0;
            if (!rw_q) begin
              rdata_d = mem_rdata;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign mem_en    = memEn_q;
  assign mem_rw    = memEn_q & rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign cpu_ack   = cpuAck_q;
  assign dma_ack   = dmaAck_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Purpose : Directed, self-checking bench for mem_bus_arbiter with the
//           default parameters (STARVE_LIMIT=4, TIMEOUT=15).
//           Inputs are driven and outputs sampled on the falling clock
//           edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_rw, dma_req, dma_rw;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, err, mem_en, mem_rw, mem_ready;
  logic [1:0]  owner;

  int checkCount = 0;
  int errorCount = 0;

  mem_bus_arbiter #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (16),
    .STARVE_LIMIT (4),
    .TIMEOUT      (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_rw    (dma_rw),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .owner     (owner)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any
  // difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives both requester bundles in one call.
  task automatic applyStimulus(input logic cReq, input logic cRw,
                               input logic [15:0] cAddr, input logic [7:0] cWdata,
                               input logic dReq, input logic dRw,
                               input logic [15:0] dAddr, input logic [7:0] dWdata);
    cpu_req   = cReq;
    cpu_rw    = cRw;
    cpu_addr  = cAddr;
    cpu_wdata = cWdata;
    dma_req   = dReq;
    dma_rw    = dRw;
    dma_addr  = dAddr;
    dma_wdata = dWdata;
  endtask

  logic [1:0] grantSeq [6];
  int         enCycles;
  bit         found;

  initial begin
    grantSeq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);

    // Reset state.
    checkOutput("reset mem_en", mem_en, 0);
    checkOutput("reset owner", owner, 0);
    checkOutput("reset acks", {cpu_ack, dma_ack}, 0);
    checkOutput("reset rdata/err", {rdata, err}, 0);
    checkOutput("reset mem_addr/wdata/rw", {mem_addr, mem_wdata, mem_rw}, 0);
    rst = 1'b0;
    @(negedge clk);

    // CPU read with no wait states.
    applyStimulus(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b1;
    mem_rdata = 8'hA5;
    @(negedge clk);
    checkOutput("rd mem_en", mem_en, 1);
    checkOutput("rd mem_addr", mem_addr, 16'h1234);
    checkOutput("rd mem_rw", mem_rw, 0);
    checkOutput("rd owner", owner, 2'b01);
    checkOutput("rd early ack", cpu_ack, 0);
    @(negedge clk);
    checkOutput("rd cpu_ack", cpu_ack, 1);
    checkOutput("rd dma_ack", dma_ack, 0);
    checkOutput("rd rdata", rdata, 8'hA5);
    checkOutput("rd err", err, 0);
    checkOutput("rd mem_en off", mem_en, 0);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("rd ack one cycle", cpu_ack, 0);
    checkOutput("rd owner released", owner, 0);

    // DMA write with two wait states.
    applyStimulus(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0200, 8'h3C);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("wr mem_en c%0d", c), mem_en, 1);
      checkOutput($sformatf("wr rw/addr/wdata c%0d", c), {mem_rw, mem_addr, mem_wdata},
                  {1'b1, 16'h0200, 8'h3C});
      checkOutput($sformatf("wr owner c%0d", c), owner, 2'b10);
      checkOutput($sformatf("wr no ack c%0d", c), dma_ack, 0);
      if (c == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("wr dma_ack", dma_ack, 1);
    checkOutput("wr cpu_ack", cpu_ack, 0);
    checkOutput("wr err", err, 0);
    checkOutput("wr owner in resp", owner, 2'b10);
    checkOutput("wr mem_en/rw off", {mem_en, mem_rw}, 0);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);

    // Contention: CPU wins four times, then the starved DMA is forced
    // through.
    applyStimulus(1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00);
    mem_ready = 1'b1;
    mem_rdata = 8'h5A;
    for (int g = 0; g < 6; g++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (cpu_ack || dma_ack) begin
          found = 1'b1;
          checkOutput($sformatf("starve single ack g%0d", g), {31'd0, cpu_ack && dma_ack}, 0);
          checkOutput($sformatf("starve grant g%0d", g), {dma_ack, cpu_ack}, grantSeq[g]);
        end
      end
      checkOutput($sformatf("starve ack seen g%0d", g), {31'd0, found}, 1);
    end
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("starve idle owner", owner, 0);

    // Timeout: mem_ready never arrives.
    applyStimulus(1, 0, 16'h4000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_rdata = 8'hEE;
    enCycles  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mem_en) break;
      enCycles++;
    end
    checkOutput("tmo mem_en cycles", enCycles, 15);
    checkOutput("tmo cpu_ack", cpu_ack, 1);
    checkOutput("tmo err", err, 1);
    checkOutput("tmo rdata held", rdata, 8'h5A);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("tmo err cleared", err, 0);

    // Access after a timeout completes cleanly.
    applyStimulus(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b1;
    mem_rdata = 8'h77;
    repeat (2) @(negedge clk);
    checkOutput("post-tmo ack/err", {cpu_ack, err}, 2'b10);
    checkOutput("post-tmo rdata", rdata, 8'h77);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);

    // mem_ready arrives in the same cycle the timeout expires.
    applyStimulus(1, 0, 16'h0030, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (15) @(negedge clk);
    checkOutput("edge still accessing", mem_en, 1);
    mem_ready = 1'b1;
    mem_rdata = 8'hC3;
    @(negedge clk);
    checkOutput("edge ack/err", {cpu_ack, err}, 2'b10);
    checkOutput("edge rdata", rdata, 8'hC3);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);

    // Reset during the second ACCESS cycle, then re-arbitration.
    applyStimulus(1, 0, 16'h0ABC, 8'h00, 0, 0, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("rst pre mem_en", mem_en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst async mem_en/owner", {mem_en, owner}, 0);
    checkOutput("rst async acks", {cpu_ack, dma_ack}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst regrant mem_en", mem_en, 1);
    checkOutput("rst regrant owner/addr", {owner, mem_addr}, {2'b01, 16'h0ABC});
    mem_ready = 1'b1;
    mem_rdata = 8'h19;
    @(negedge clk);
    checkOutput("rst regrant ack", cpu_ack, 1);
    checkOutput("rst regrant rdata", rdata, 8'h19);
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
    mem_ready = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus (address, data, rw) between the CPU core's load/store/fetch path and the DMA engine.
- Latches the winning request, drives one memory access with wait-state support via mem_ready, and returns read data and a one-cycle ack to the winner.
- Uses fixed CPU priority with a DMA anti-starvation counter and an access timeout.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 16, address width (ABH:ABL)
STARVE_LIMIT, 4, consecutive DMA losses before DMA is forced to win (1..15)
TIMEOUT, 15, max ACCESS cycles waiting for mem_ready before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_rw  in  1  1=write(store), 0=read
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
dma_req / dma_rw / dma_addr / dma_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  DMA request bundle, same rules as CPU
dma_ack  out  1  one-cycle completion pulse to DMA
rdata  out  DATA_WIDTH  read data, valid in the ack cycle
err  out  1  high with ack when the access timed out
mem_en  out  1  memory access enable
mem_rw  out  1  1=write
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
mem_ready  in  1  access completes in this cycle
owner  out  2  00 none, 01 CPU, 10 DMA

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs are 0: mem_en, acks, err, rdata, mem_addr, mem_wdata, mem_rw, owner. Starve counter=0, timeout counter=0.
- A reset during ACCESS aborts the access. No ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick a winner:
    - DMA wins if dma_req and starve_cnt==STARVE_LIMIT.
    - Else CPU wins if cpu_req.
    - Else DMA wins.
  - Latch the winner's rw/addr/wdata into mem_* registers and set owner. Go to ACCESS next cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when CPU wins while dma_req=1.
  - Clears whenever DMA wins.
- ACCESS:
  - mem_en=1, driven from registers.
  - Requester inputs are ignored after latching.
  - Timeout counter increments each cycle.
  - If mem_ready=1: capture mem_rdata into rdata (0 for writes, rdata is don't-care but held), go to RESP.
  - Else if the counter reaches TIMEOUT: set err=1, rdata unchanged, go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins, err=0.
- RESP:
  - mem_en=0, owner's ack=1 for exactly one cycle, err valid.
  - Next cycle go to IDLE; owner=00, err=0, timeout counter=0.
- Latency: minimum 3 cycles from the req sample edge to the ack cycle (IDLE sample, 1-cycle ACCESS, RESP).
  - Each wait state adds one cycle.
  - Back-to-back accesses are 3 cycles apart minimum.
- Requester protocol: req must stay high until ack. Dropping req after the grant does not cancel the access; ack is still pulsed.
- mem_en, mem_rw, mem_addr, mem_wdata are registered outputs with no combinational path from requester inputs.
- mem_rw is forced 0 whenever mem_en=0.
- cpu_ack and dma_ack are never high simultaneously.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/ACCESS/RESP), the owner encoding (NONE/CPU/DMA), and the DATA_WIDTH/ADDR_WIDTH defaults shared with the control unit.
- One natural sub-module, arb_starve_counter: a saturating counter with inc/clr/limit-reached outputs, also reused for the timeout counter.

Test Plan:
- CPU read alone: cpu_req=1, cpu_addr=0x1234, cpu_rw=0, mem_ready=1 in the first ACCESS cycle, mem_rdata=0xA5 -> mem_en one cycle with mem_addr=0x1234; cpu_ack + rdata=0xA5 two cycles after the sample edge; err=0.
- Write with 2 wait states: dma_req, dma_rw=1, dma_addr=0x0200, dma_wdata=0x3C, mem_ready on the 3rd ACCESS cycle -> mem_en high 3 cycles, mem_rw=1, mem_wdata=0x3C; dma_ack one cycle later; owner=10 throughout.
- Contention/starvation: cpu_req and dma_req held high continuously, STARVE_LIMIT=4 -> grant sequence CPU,CPU,CPU,CPU,DMA,CPU...; the counter resets after the DMA grant.
- Timeout: cpu read, mem_ready never asserted, TIMEOUT=15 -> mem_en high 15 cycles, then cpu_ack=1 with err=1; next access err=0.
- Reset mid-access: assert rst during the 2nd ACCESS cycle -> mem_en, owner, ack drop to 0 immediately (asynchronously); after release, a pending cpu_req is re-arbitrated from IDLE.
- Simultaneous mem_ready and timeout expiry on the same cycle -> ack with err=0 and rdata=mem_rdata.
